// File: rtl/spr_arbiter.sv
// spr_arbiter: two-master request/grant arbiter in front of one single-port synchronous RAM.
// Define SPR_ARB_RR_EN for round-robin tie-break; without it master 0 always wins ties.
module spr_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_din,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m0_dout,
    output logic [DATA_WIDTH-1:0] m1_dout,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    owner;
    logic                    owner_next;
    logic                    any_req;
    logic                    win;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_din;

    logic                    ram_en_next;
    logic                    ram_we_next;
    logic [ADDR_WIDTH-1:0]   ram_addr_next;
    logic [DATA_WIDTH-1:0]   ram_din_next;
    logic                    m0_gnt_next;
    logic                    m1_gnt_next;
    logic                    m0_rvalid_next;
    logic                    m1_rvalid_next;
    logic [DATA_WIDTH-1:0]   m0_dout_next;
    logic [DATA_WIDTH-1:0]   m1_dout_next;
    logic                    busy_next;

    assign any_req = m0_req | m1_req;

`ifdef SPR_ARB_RR_EN
    // Last-grant pointer; reset value 1 makes the first tie go to master 0.
    logic last_grant;

    always_comb begin
        if (m0_req && m1_req) begin
            win = ~last_grant;
        end else begin
            win = ~m0_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_grant <= win;
        end
    end
`else
    // Fixed priority: master 1 wins only when master 0 is not requesting.
    always_comb begin
        win = ~m0_req;
    end
`endif

    assign win_we   = win ? m1_we   : m0_we;
    assign win_addr = win ? m1_addr : m0_addr;
    assign win_din  = win ? m1_din  : m0_din;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_dout   <= '0;
            m1_dout   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            ram_en    <= ram_en_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_din   <= ram_din_next;
            m0_gnt    <= m0_gnt_next;
            m1_gnt    <= m1_gnt_next;
            m0_rvalid <= m0_rvalid_next;
            m1_rvalid <= m1_rvalid_next;
            m0_dout   <= m0_dout_next;
            m1_dout   <= m1_dout_next;
            busy      <= busy_next;
        end
    end

    // Next-state logic; requests are looked at only in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ram_we ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Next values for the output registers; strobes default low, data holds.
    always_comb begin
        ram_en_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr;
        ram_din_next   = ram_din;
        owner_next     = owner;
        m0_gnt_next    = 1'b0;
        m1_gnt_next    = 1'b0;
        m0_rvalid_next = 1'b0;
        m1_rvalid_next = 1'b0;
        m0_dout_next   = m0_dout;
        m1_dout_next   = m1_dout;
        busy_next      = (state_next != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    ram_en_next   = 1'b1;
                    ram_we_next   = win_we;
                    ram_addr_next = win_addr;
                    ram_din_next  = win_din;
                    owner_next    = win;
                    m0_gnt_next   = ~win;
                    m1_gnt_next   = win;
                end
            end
            ST_RDATA: begin
                if (owner) begin
                    m1_dout_next   = ram_dout;
                    m1_rvalid_next = 1'b1;
                end else begin
                    m0_dout_next   = ram_dout;
                    m0_rvalid_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_spr_arbiter.sv
// tb_spr_arbiter: directed vector table, multi-cycle corner sequences and a randomized
// scoreboard run for spr_arbiter against a behavioural RAM and arbitration model.
module tb_spr_arbiter;

`ifdef SPR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_din, m1_addr, m1_din;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [7:0] m0_dout, m1_dout;
    logic       ram_en, ram_we, busy;
    logic [7:0] ram_addr, ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spr_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_dout(m0_dout), .m1_dout(m1_dout),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    // Single-port synchronous RAM with 1-cycle read latency.
    logic [7:0] mem [256];
    logic [7:0] ram_rd = 8'h00;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_rd <= mem[ram_addr];
        end
    end
    assign ram_dout = ram_rd;

    typedef struct {
        int         mst;
        bit         we;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] rdat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int m, input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        if (m == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_din = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_din = d;
        end
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_gnt : m1_gnt;
    endfunction

    function automatic logic rvalid_of(input int m);
        return (m == 0) ? m0_rvalid : m1_rvalid;
    endfunction

    function automatic logic [7:0] dout_of(input int m);
        return (m == 0) ? m0_dout : m1_dout;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One access from an idle arbiter, checked cycle by cycle from T+1 to T+3.
    task automatic do_access(input vec_t v);
        int o;
        o = 1 - v.mst;
        @(negedge clk);
        drive(v.mst, 1'b1, v.we, v.addr, v.din);
        @(negedge clk);
        chk("acc_gnt", 32'(gnt_of(v.mst)), 32'd1);
        chk("acc_other_gnt", 32'(gnt_of(o)), 32'd0);
        chk("acc_ram_en", 32'(ram_en), 32'd1);
        chk("acc_ram_we", 32'(ram_we), 32'(v.we));
        chk("acc_ram_addr", 32'(ram_addr), 32'(v.addr));
        if (v.we) chk("acc_ram_din", 32'(ram_din), 32'(v.din));
        drive(v.mst, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("acc_gnt_pulse", 32'(gnt_of(v.mst)), 32'd0);
        chk("acc_ram_en_off", 32'(ram_en), 32'd0);
        chk("acc_rvalid_early", 32'(rvalid_of(v.mst)), 32'd0);
        chk("acc_busy_t2", 32'(busy), 32'(!v.we));
        if (!v.we) begin
            @(negedge clk);
            chk("acc_rvalid", 32'(rvalid_of(v.mst)), 32'd1);
            chk("acc_other_rvalid", 32'(rvalid_of(o)), 32'd0);
            chk("acc_dout", 32'(dout_of(v.mst)), 32'(v.rdat));
            chk("acc_busy_t3", 32'(busy), 32'd0);
        end
    endtask

    vec_t       tbl [8];
    logic [7:0] shadow [256];
    logic       mreq [2];
    logic       mwe [2];
    logic [7:0] maddr [2];
    logic [7:0] mdin [2];
    logic [7:0] exp_dout [2];

    initial begin
        int cyc, free_at, busy_from, pend_cyc, pend_m, rv_cyc, rv_m, last, w;
        logic       pend_we, fresh;
        logic [7:0] pend_addr, pend_din, rv_data;

        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 32'd0);
        chk("rst_dout", 32'({m0_dout, m1_dout}), 32'd0);
        chk("rst_ram_bus", 32'({ram_we, ram_addr, ram_din}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        tbl[0] = '{0, 1'b1, 8'h05, 8'hA5, 8'h00};
        tbl[1] = '{0, 1'b1, 8'h05, 8'h3C, 8'h00};
        tbl[2] = '{1, 1'b0, 8'h05, 8'h00, 8'h3C};
        tbl[3] = '{1, 1'b1, 8'h10, 8'h5A, 8'h00};
        tbl[4] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A};
        tbl[5] = '{1, 1'b1, 8'hFF, 8'hFF, 8'h00};
        tbl[6] = '{0, 1'b0, 8'hFF, 8'h00, 8'hFF};
        tbl[7] = '{1, 1'b0, 8'h05, 8'h00, 8'h3C};
        for (int i = 0; i < 8; i++) do_access(tbl[i]);

        // Reset during RDATA: everything clears without a clock edge, no late rvalid.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstrd_ram", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'd0);
        chk("rstrd_strobes", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy}), 32'd0);
        chk("rstrd_dout", 32'({m0_dout, m1_dout}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstrd_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        end
        do_access('{0, 1'b0, 8'h05, 8'h00, 8'h3C});

        // Reset during ISSUE cuts the RAM enable immediately.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h40, 8'h11);
        @(negedge clk);
        chk("rstis_en_before", 32'(ram_en), 32'd1);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        chk("rstis_en_cut", 32'({ram_en, m0_gnt, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Tie: both masters hold write requests through three grants.
        reset_dut();
        drive(0, 1'b1, 1'b1, 8'h20, 8'h01);
        drive(1, 1'b1, 1'b1, 8'h21, 8'h02);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk("tie_m0_gnt", 32'(m0_gnt), 32'(RR ? (g != 1) : 1'b1));
            chk("tie_m1_gnt", 32'(m1_gnt), 32'(RR ? (g == 1) : 1'b0));
            if (g == 2) begin
                drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
                drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            @(negedge clk);
            chk("tie_idle_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        end

        // Back-to-back writes from m0: ram_en every second cycle.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h00, 8'h80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_en", 32'(ram_en), 32'd1);
            chk("b2b_addr", 32'(ram_addr), 32'(i));
            chk("b2b_gnt", 32'(m0_gnt), 32'd1);
            if (i < 2) drive(0, 1'b1, 1'b1, 8'(i + 1), 8'(8'h81 + i));
            else       drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk);
            chk("b2b_gap", 32'(ram_en), 32'd0);
        end

        // Dropped request: m1 pulses req only while m0 is in ISSUE.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h30, 8'h77);
        @(negedge clk);
        chk("drop_m0_gnt", 32'(m0_gnt), 32'd1);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h31, 8'h00);
        #2;
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop_no_m1_gnt", 32'(m1_gnt), 32'd0);
            chk("drop_no_en", 32'(ram_en), 32'd0);
        end

        // Randomized traffic against a cycle-level model of the arbitration rules.
        reset_dut();
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        cyc = 0; free_at = 0; busy_from = 0; pend_cyc = -1; pend_m = 0;
        rv_cyc = -1; rv_m = 0; rv_data = 8'h00; last = 1;
        pend_we = 1'b0; pend_addr = 8'h00; pend_din = 8'h00;
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0; mwe[m] = 1'b0; maddr[m] = 8'h00; mdin[m] = 8'h00;
            exp_dout[m] = 8'h00;
        end
        repeat (3000) begin
            @(negedge clk);
            cyc++;
            for (int m = 0; m < 2; m++) begin
                chk("rnd_gnt", 32'(gnt_of(m)), 32'(pend_cyc == cyc && pend_m == m));
                chk("rnd_rvalid", 32'(rvalid_of(m)), 32'(rv_cyc == cyc && rv_m == m));
                if (rv_cyc == cyc && rv_m == m) exp_dout[m] = rv_data;
                chk("rnd_dout", 32'(dout_of(m)), 32'(exp_dout[m]));
            end
            chk("rnd_ram_en", 32'(ram_en), 32'(pend_cyc == cyc));
            if (pend_cyc == cyc) begin
                chk("rnd_ram_we", 32'(ram_we), 32'(pend_we));
                chk("rnd_ram_addr", 32'(ram_addr), 32'(pend_addr));
                if (pend_we) begin
                    chk("rnd_ram_din", 32'(ram_din), 32'(pend_din));
                    shadow[pend_addr] = pend_din;
                end else begin
                    rv_cyc = cyc + 2; rv_m = pend_m; rv_data = shadow[pend_addr];
                end
            end
            chk("rnd_busy", 32'(busy), 32'(cyc >= busy_from && cyc < free_at));
            for (int m = 0; m < 2; m++) begin
                fresh = 1'b0;
                if (pend_cyc == cyc && pend_m == m) begin
                    mreq[m] = 1'($urandom_range(0, 1)); fresh = 1'b1;
                end else if (!mreq[m]) begin
                    mreq[m] = ($urandom_range(0, 9) < 4); fresh = 1'b1;
                end
                if (fresh) begin
                    mwe[m] = 1'($urandom_range(0, 1));
                    maddr[m] = 8'($urandom_range(0, 15));
                    mdin[m] = 8'($urandom);
                end
                drive(m, mreq[m], mwe[m], maddr[m], mdin[m]);
            end
            if (cyc >= free_at && (mreq[0] || mreq[1])) begin
                if (mreq[0] && mreq[1]) w = RR ? (1 - last) : 0;
                else                    w = mreq[0] ? 0 : 1;
                last = w;
                pend_cyc = cyc + 1; pend_m = w;
                pend_we = mwe[w]; pend_addr = maddr[w]; pend_din = mdin[w];
                busy_from = cyc + 1;
                free_at = cyc + 1 + (mwe[w] ? 1 : 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
